// File: rtl/rf_writeback_unit.sv
// Register-file write-side front end: buffers completed results, applies load
// extension on entry and drains one write per cycle with a pending-write hazard check.
module rf_writeback_unit #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      result_valid_i,
  output logic                      result_ready_o,
  input  logic [XLEN-1:0]           result_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] result_rd_i,
  input  logic                      result_is_load_i,
  input  logic [2:0]                load_funct3_i,
  input  logic [1:0]                load_offset_i,
  input  logic                      stall_i,
  output logic                      write_enable_o,
  output logic [REG_ADDR_WIDTH-1:0] write_address_o,
  output logic [XLEN-1:0]           write_data_o,
  output logic                      error_o,
  input  logic [REG_ADDR_WIDTH-1:0] hazard_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] hazard_rs2_i,
  output logic                      hazard_o
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic                      err;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]           data;
  } entry_t;

  entry_t          buf_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  entry_t          in_ent;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic            push, pop;

  assign result_ready_o = (count_q < (PW+1)'(DEPTH));
  assign push           = result_valid_i & result_ready_o;
  assign pop            = (count_q != '0) & ~stall_i;

  always_comb begin
    byte_v      = result_data_i[8*load_offset_i +: 8];
    half_v      = result_data_i[16*load_offset_i[1] +: 16];
    in_ent.err  = 1'b0;
    in_ent.rd   = result_rd_i;
    in_ent.data = result_data_i;
    if (result_is_load_i) begin
      case (load_funct3_i)
        3'b000: in_ent.data = {{(XLEN-8){byte_v[7]}}, byte_v};
        3'b100: in_ent.data = {{(XLEN-8){1'b0}}, byte_v};
        3'b001: if (load_offset_i[0]) in_ent.err = 1'b1;
                else in_ent.data = {{(XLEN-16){half_v[15]}}, half_v};
        3'b101: if (load_offset_i[0]) in_ent.err = 1'b1;
                else in_ent.data = {{(XLEN-16){1'b0}}, half_v};
        3'b010: if (load_offset_i != 2'b00) in_ent.err = 1'b1;
        default: in_ent.err = 1'b1;
      endcase
    end
    // Faulting loads are kept only to report the error on drain.
    if (in_ent.err) in_ent.data = '0;
  end

  always_ff @(posedge clk_i) begin
    if (push) buf_q[wr_ptr_q] <= in_ent;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      write_enable_o  <= 1'b0;
      write_address_o <= '0;
      write_data_o    <= '0;
      error_o         <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      write_enable_o <= 1'b0;
      error_o        <= 1'b0;
      if (pop) begin
        write_enable_o  <= ~buf_q[rd_ptr_q].err & (buf_q[rd_ptr_q].rd != '0);
        error_o         <= buf_q[rd_ptr_q].err;
        write_address_o <= buf_q[rd_ptr_q].rd;
        write_data_o    <= buf_q[rd_ptr_q].data;
      end
    end
  end

  function automatic logic rs_match(input logic [REG_ADDR_WIDTH-1:0] rd);
    return ((hazard_rs1_i != '0) && (rd == hazard_rs1_i)) ||
           ((hazard_rs2_i != '0) && (rd == hazard_rs2_i));
  endfunction

  // Slot i is occupied when its distance from the read pointer is below count.
  always_comb begin
    hazard_o = write_enable_o & rs_match(write_address_o);
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - rd_ptr_q} < count_q) && !buf_q[i].err && rs_match(buf_q[i].rd))
        hazard_o = 1'b1;
    end
  end
endmodule
